layer_result_pingpong_mem: RTL and testbench
============================================

# layer_result_pingpong_mem

Parametrised, double-buffered feature-map result store between a CNN layer's output stage and the next layer's input fetch. The producer layer fills one bank by (row, col) address while the consumer layer reads the previously committed bank. Bank ownership is passed by explicit commit/release handshakes, with an optional auto-commit on a full map. Default geometry is 12×12 maps of 128-bit entries, i.e. two banks of 144 words.

## Interface
Parameters:
- DATA_W, 128, width of one stored result word (all channels of one pixel).
- MAP_W, 12, map width in columns.
- MAP_H, 12, map height in rows.
- AUTO_COMMIT, 0, when 1, the bank commits automatically on its MAP_W*MAP_H-th accepted write.

Ports:
- clk  in  1  the one clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- save_enable  in  1  write strobe.
- save_row_addr  in  16  write row.
- save_col_addr  in  16  write column.
- layer_result_store_data_in  in  DATA_W  write data.
- save_commit  in  1  hands the current fill bank to the consumer.
- wr_ready  out  1  current fill bank is writable.
- fill_count  out  16  accepted writes into the current fill bank.
- read_signal  in  1  read strobe.
- read_row_addr  in  16  read row.
- read_col_addr  in  16  read column.
- read_release  in  1  returns the current read bank to the producer.
- rd_ready  out  1  current read bank holds a committed map.
- layer_result_output  out  DATA_W  read data; all zeros when layer_result_valid=0.
- layer_result_valid  out  1  qualifies layer_result_output.
- overflow  out  1  sticky flag.
- underflow  out  1  sticky flag.
- range_err  out  1  sticky flag.

## Operation
- Storage: 2 banks × DEPTH words, where DEPTH = MAP_W*MAP_H. Linear index = row*MAP_W + col, computed at full width with no truncation. Contents are not cleared by rst.
- State: bank_full[1:0], wr_bank, rd_bank, fill_count.
- wr_ready = !bank_full[wr_bank]; rd_ready = bank_full[rd_bank].
- Write, when save_enable is high:
  - row ≥ MAP_H or col ≥ MAP_W: write dropped, range_err set.
  - !wr_ready: write dropped, overflow set.
  - Otherwise: word written to bank wr_bank and fill_count increments, saturating at 16'hFFFF.
  - Rewriting the same address is legal; each accepted write still counts.
- Commit (save_commit=1, or AUTO_COMMIT=1 with the accepted write bringing fill_count to DEPTH):
  - If wr_ready: bank_full[wr_bank] set, wr_bank toggles, fill_count cleared to 0.
  - If !wr_ready: overflow set, no state change.
  - save_commit coinciding with an auto-commit counts as one commit.
  - A write accepted in the commit cycle lands in the committing bank before it toggles.
- Read, when read_signal is high:
  - rd_ready and address in range: bank rd_bank is read.
  - !rd_ready: underflow set, no valid output.
  - Address out of range: range_err set, no valid output.
- Release, when read_release is high:
  - If rd_ready: bank_full[rd_bank] cleared, rd_bank toggles.
  - Otherwise: underflow set, no state change.
  - A read in the same cycle uses the pre-release rd_bank.
- Commit and release in the same cycle cannot target the same bank, because commit needs !full and release needs full. Both take effect in that cycle.
- Flags overflow, underflow and range_err clear only on rst.

## Timing
- rst (sampled at an edge): bank_full=0, wr_bank=0, rd_bank=0, fill_count=0, all flags 0, layer_result_valid=0, layer_result_output=0. Takes effect mid-fill or mid-drain; any in-flight read result is suppressed.
- Write latency: data is stored at the edge where save_enable is sampled. It becomes readable only after its bank is committed and that bank becomes rd_bank.
- Read latency is 1 cycle: read_signal at edge N gives layer_result_valid=1 and data for cycle N+1. Back-to-back reads give one result per cycle.
- wr_ready, rd_ready and fill_count reflect state after the previous edge. A commit at edge N makes rd_ready=1 in cycle N+1 if that bank is rd_bank.
- After rst, both banks are empty: the producer may fill and commit two maps before it stalls.

## Test plan
- Fill bank0 with data = 1000+index for all 144 addresses, commit, then read (0,0), (5,7) and (11,11): expect valid one cycle later with 1000, 1067 and 1143.
- Commit bank0 and bank1 without any release, then write (0,0): expect wr_ready=0, write dropped, overflow=1. Release, then read bank1 data.
- Read with rd_ready=0: expect underflow=1, valid stays 0, output 0. Release with rd_ready=0: expect rd_bank unchanged.
- Write (12,0) and then read (0,12): expect range_err=1, fill_count unchanged, valid=0.
- With AUTO_COMMIT=1, 144 accepted writes: expect rd_ready=1 the cycle after the 144th write, fill_count=0, wr_bank=1, with no save_commit issued.
- Pulse rst mid-fill after 50 writes with a read in flight: expect all outputs 0 next cycle and fill_count=0. Then commit an empty fill and read: data is unspecified, and valid asserts as normal.

Source files
------------

// File: rtl/layer_result_pingpong_mem.sv
`default_nettype none
// ============================================================================
// Module      : layer_result_pingpong_mem
// Description : Double-buffered CNN feature-map result store. The producer fills
//               one bank while the consumer reads the other. Banks change hands
//               through commit and release handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module layer_result_pingpong_mem #(
  parameter int DATA_W      = 128,
  parameter int MAP_W       = 12,
  parameter int MAP_H       = 12,
  parameter int AUTO_COMMIT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              save_enable,
  input  logic [15:0]       save_row_addr,
  input  logic [15:0]       save_col_addr,
  input  logic [DATA_W-1:0] layer_result_store_data_in,
  input  logic              save_commit,
  output logic              wr_ready,
  output logic [15:0]       fill_count,
  input  logic              read_signal,
  input  logic [15:0]       read_row_addr,
  input  logic [15:0]       read_col_addr,
  input  logic              read_release,
  output logic              rd_ready,
  output logic [DATA_W-1:0] layer_result_output,
  output logic              layer_result_valid,
  output logic              overflow,
  output logic              underflow,
  output logic              range_err
);

  localparam int          DEPTH   = MAP_W * MAP_H;
  localparam int          AW      = $clog2(2 * DEPTH);
  localparam logic [31:0] MAP_W_U = 32'(MAP_W);
  localparam logic [31:0] MAP_H_U = 32'(MAP_H);
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  logic [DATA_W-1:0] mem [2*DEPTH];

  logic [1:0]    bank_full;
  logic [1:0]    full_next;
  logic          wr_bank;
  logic          rd_bank;
  logic          wr_in_range;
  logic          rd_in_range;
  logic [AW-1:0] wr_lin;
  logic [AW-1:0] rd_lin;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [15:0]   fill_inc;
  logic          wr_accept;
  logic          auto_fire;
  logic          commit_req;
  logic          do_commit;
  logic          do_release;
  logic          rd_fire;

  // Range checks use the full 16-bit addresses, so large rows never alias.
  assign wr_in_range = (32'(save_row_addr) < MAP_H_U) && (32'(save_col_addr) < MAP_W_U);
  assign rd_in_range = (32'(read_row_addr) < MAP_H_U) && (32'(read_col_addr) < MAP_W_U);

  assign wr_lin  = AW'(32'(save_row_addr) * MAP_W_U + 32'(save_col_addr));
  assign rd_lin  = AW'(32'(read_row_addr) * MAP_W_U + 32'(read_col_addr));
  assign wr_addr = wr_bank ? (wr_lin + AW'(DEPTH)) : wr_lin;
  assign rd_addr = rd_bank ? (rd_lin + AW'(DEPTH)) : rd_lin;

  assign wr_ready = !bank_full[wr_bank];
  assign rd_ready =  bank_full[rd_bank];

  assign wr_accept  = save_enable && wr_in_range && wr_ready;
  assign fill_inc   = (fill_count == 16'hFFFF) ? fill_count : fill_count + 16'd1;
  assign auto_fire  = (AUTO_COMMIT != 0) && wr_accept && (32'(fill_inc) == DEPTH_U);
  assign commit_req = save_commit || auto_fire;
  assign do_commit  = commit_req && wr_ready;
  assign do_release = read_release && rd_ready;
  assign rd_fire    = read_signal && rd_ready && rd_in_range;

  // Commit and release never target the same bank, so both may apply at once.
  always_comb begin
    full_next = bank_full;
    if (do_release) full_next[rd_bank] = 1'b0;
    if (do_commit)  full_next[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_accept) mem[wr_addr] <= layer_result_store_data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_full           <= 2'b00;
      wr_bank             <= 1'b0;
      rd_bank             <= 1'b0;
      fill_count          <= 16'd0;
      overflow            <= 1'b0;
      underflow           <= 1'b0;
      range_err           <= 1'b0;
      layer_result_valid  <= 1'b0;
      layer_result_output <= '0;
    end else begin
      bank_full <= full_next;
      if (do_commit)  wr_bank <= ~wr_bank;
      if (do_release) rd_bank <= ~rd_bank;

      if (do_commit)      fill_count <= 16'd0;
      else if (wr_accept) fill_count <= fill_inc;

      overflow  <= overflow
                 | (save_enable && wr_in_range && !wr_ready)
                 | (commit_req && !wr_ready);
      underflow <= underflow
                 | (read_signal && !rd_ready)
                 | (read_release && !rd_ready);
      range_err <= range_err
                 | (save_enable && !wr_in_range)
                 | (read_signal && !rd_in_range);

      layer_result_valid  <= rd_fire;
      layer_result_output <= rd_fire ? mem[rd_addr] : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_layer_result_pingpong_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_layer_result_pingpong_mem
// Description : Self-checking bench with directed scenarios and a randomized
//               run against a map-FIFO reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_layer_result_pingpong_mem;

  localparam int DW    = 128;
  localparam int MW    = 12;
  localparam int MH    = 12;
  localparam int DEPTH = MW * MH;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          save_enable = 1'b0;
  logic [15:0]   save_row_addr = 16'd0;
  logic [15:0]   save_col_addr = 16'd0;
  logic [DW-1:0] data_in = '0;
  logic          save_commit = 1'b0;
  logic          read_signal = 1'b0;
  logic [15:0]   read_row_addr = 16'd0;
  logic [15:0]   read_col_addr = 16'd0;
  logic          read_release = 1'b0;

  logic          wr_ready, rd_ready, layer_result_valid, overflow, underflow, range_err;
  logic [15:0]   fill_count;
  logic [DW-1:0] layer_result_output;

  logic          ac_wr_ready, ac_rd_ready, ac_valid, ac_ovf, ac_unf, ac_rng;
  logic [15:0]   ac_fill_count;
  logic [DW-1:0] ac_out;

  always #5 clk = ~clk;

  layer_result_pingpong_mem #(.DATA_W(DW), .MAP_W(MW), .MAP_H(MH), .AUTO_COMMIT(0)) dut (
    .clk(clk), .rst(rst),
    .save_enable(save_enable), .save_row_addr(save_row_addr), .save_col_addr(save_col_addr),
    .layer_result_store_data_in(data_in), .save_commit(save_commit),
    .wr_ready(wr_ready), .fill_count(fill_count),
    .read_signal(read_signal), .read_row_addr(read_row_addr), .read_col_addr(read_col_addr),
    .read_release(read_release), .rd_ready(rd_ready),
    .layer_result_output(layer_result_output), .layer_result_valid(layer_result_valid),
    .overflow(overflow), .underflow(underflow), .range_err(range_err)
  );

  layer_result_pingpong_mem #(.DATA_W(DW), .MAP_W(MW), .MAP_H(MH), .AUTO_COMMIT(1)) dut_ac (
    .clk(clk), .rst(rst),
    .save_enable(save_enable), .save_row_addr(save_row_addr), .save_col_addr(save_col_addr),
    .layer_result_store_data_in(data_in), .save_commit(save_commit),
    .wr_ready(ac_wr_ready), .fill_count(ac_fill_count),
    .read_signal(read_signal), .read_row_addr(read_row_addr), .read_col_addr(read_col_addr),
    .read_release(read_release), .rd_ready(ac_rd_ready),
    .layer_result_output(ac_out), .layer_result_valid(ac_valid),
    .overflow(ac_ovf), .underflow(ac_unf), .range_err(ac_rng)
  );

  int checks = 0;
  int errors = 0;

  // Reference model of the AUTO_COMMIT=0 instance: a map being filled plus a
  // FIFO of up to two committed maps, each word tagged as written or not.
  logic [DW-1:0] cur_d [DEPTH];
  bit            cur_w [DEPTH];
  logic [DW-1:0] map_d [2][DEPTH];
  bit            map_w [2][DEPTH];
  int            n_maps = 0;
  int            head = 0;
  int            fc = 0;
  bit            e_ovf = 0, e_unf = 0, e_rng = 0, e_valid = 0, e_known = 1;
  logic [DW-1:0] e_data = '0;

  function automatic bit in_rng(input logic [15:0] r, input logic [15:0] c);
    return (int'(r) < MH) && (int'(c) < MW);
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Advance one clock, update the model from the inputs sampled at that edge.
  task automatic step();
    int pre_n, slot, idx;
    @(posedge clk);
    if (rst) begin
      n_maps = 0; head = 0; fc = 0;
      e_ovf = 0; e_unf = 0; e_rng = 0; e_valid = 0; e_known = 1; e_data = '0;
      foreach (cur_w[i]) cur_w[i] = 0;
    end else begin
      pre_n   = n_maps;
      e_valid = 0; e_known = 1; e_data = '0;
      if (read_signal) begin
        if (pre_n == 0) e_unf = 1;
        if (!in_rng(read_row_addr, read_col_addr)) e_rng = 1;
        else if (pre_n > 0) begin
          idx     = int'(read_row_addr) * MW + int'(read_col_addr);
          e_valid = 1;
          e_known = map_w[head][idx];
          e_data  = map_d[head][idx];
        end
      end
      if (save_enable) begin
        if (!in_rng(save_row_addr, save_col_addr)) e_rng = 1;
        else if (pre_n == 2) e_ovf = 1;
        else begin
          idx        = int'(save_row_addr) * MW + int'(save_col_addr);
          cur_d[idx] = data_in;
          cur_w[idx] = 1;
          if (fc < 65535) fc = fc + 1;
        end
      end
      if (save_commit) begin
        if (pre_n < 2) begin
          slot = (head + pre_n) % 2;
          for (int i = 0; i < DEPTH; i++) begin
            map_d[slot][i] = cur_d[i];
            map_w[slot][i] = cur_w[i];
            cur_w[i]       = 0;
          end
          fc     = 0;
          n_maps = n_maps + 1;
        end else e_ovf = 1;
      end
      if (read_release) begin
        if (pre_n > 0) begin
          head   = 1 - head;
          n_maps = n_maps - 1;
        end else e_unf = 1;
      end
    end
    #1;
  endtask

  task automatic drive_clear();
    rst = 0; save_enable = 0; save_commit = 0; read_signal = 0; read_release = 0;
  endtask

  task automatic do_rst();
    drive_clear(); rst = 1; step(); drive_clear();
  endtask

  task automatic do_write(input int r, input int c, input logic [DW-1:0] d);
    drive_clear();
    save_enable = 1; save_row_addr = 16'(r); save_col_addr = 16'(c); data_in = d;
    step(); drive_clear();
  endtask

  task automatic do_commit();
    drive_clear(); save_commit = 1; step(); drive_clear();
  endtask

  task automatic do_release();
    drive_clear(); read_release = 1; step(); drive_clear();
  endtask

  task automatic do_read(input int r, input int c);
    drive_clear();
    read_signal = 1; read_row_addr = 16'(r); read_col_addr = 16'(c);
    step(); drive_clear();
  endtask

  task automatic test_reset();
    do_rst();
    checks++; if ({wr_ready, rd_ready} !== 2'b10) begin errors++; $display("FAIL reset_ready got %b exp 10", {wr_ready, rd_ready}); end
    checks++; if (fill_count !== 16'd0) begin errors++; $display("FAIL reset_fill got %0d exp 0", fill_count); end
    checks++; if ({overflow, underflow, range_err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {overflow, underflow, range_err}); end
    checks++; if (layer_result_valid !== 1'b0 || layer_result_output !== '0) begin errors++; $display("FAIL reset_out got valid=%b data=%0h exp 0/0", layer_result_valid, layer_result_output); end
    checks++; if ({ac_wr_ready, ac_rd_ready, ac_fill_count} !== {2'b10, 16'd0}) begin errors++; $display("FAIL reset_ac got %b/%0d exp 10/0", {ac_wr_ready, ac_rd_ready}, ac_fill_count); end
  endtask

  task automatic test_fill_read();
    do_rst();
    for (int i = 0; i < DEPTH; i++) do_write(i / MW, i % MW, DW'(1000 + i));
    checks++; if ({wr_ready, rd_ready, fill_count} !== {2'b10, 16'd144}) begin errors++; $display("FAIL filled_state got %b/%0d exp 10/144", {wr_ready, rd_ready}, fill_count); end
    do_commit();
    checks++; if ({wr_ready, rd_ready, fill_count} !== {2'b11, 16'd0}) begin errors++; $display("FAIL commit_state got %b/%0d exp 11/0", {wr_ready, rd_ready}, fill_count); end
    do_read(0, 0);
    checks++; if (layer_result_valid !== 1'b1 || layer_result_output !== DW'(1000)) begin errors++; $display("FAIL read_0_0 got valid=%b data=%0d exp 1/1000", layer_result_valid, layer_result_output); end
    do_read(5, 7);
    checks++; if (layer_result_valid !== 1'b1 || layer_result_output !== DW'(1067)) begin errors++; $display("FAIL read_5_7 got valid=%b data=%0d exp 1/1067", layer_result_valid, layer_result_output); end
    do_read(11, 11);
    checks++; if (layer_result_valid !== 1'b1 || layer_result_output !== DW'(1143)) begin errors++; $display("FAIL read_11_11 got valid=%b data=%0d exp 1/1143", layer_result_valid, layer_result_output); end
    step();
    checks++; if (layer_result_valid !== 1'b0 || layer_result_output !== '0) begin errors++; $display("FAIL read_idle got valid=%b data=%0h exp 0/0", layer_result_valid, layer_result_output); end
  endtask

  task automatic test_overflow();
    do_write(0, 0, DW'(2000));
    do_write(3, 4, DW'(2040));
    do_commit();
    checks++; if ({wr_ready, rd_ready, overflow} !== 3'b010) begin errors++; $display("FAIL both_full got %b exp 010", {wr_ready, rd_ready, overflow}); end
    do_write(0, 0, DW'(9999));
    checks++; if (overflow !== 1'b1 || fill_count !== 16'd0) begin errors++; $display("FAIL overflow_write got ovf=%b fill=%0d exp 1/0", overflow, fill_count); end
    do_release();
    checks++; if ({wr_ready, rd_ready} !== 2'b11) begin errors++; $display("FAIL after_release got %b exp 11", {wr_ready, rd_ready}); end
    do_read(0, 0);
    checks++; if (layer_result_valid !== 1'b1 || layer_result_output !== DW'(2000)) begin errors++; $display("FAIL bank1_read_0_0 got valid=%b data=%0d exp 1/2000", layer_result_valid, layer_result_output); end
    do_read(3, 4);
    checks++; if (layer_result_valid !== 1'b1 || layer_result_output !== DW'(2040)) begin errors++; $display("FAIL bank1_read_3_4 got valid=%b data=%0d exp 1/2040", layer_result_valid, layer_result_output); end
    do_release();
    checks++; if ({rd_ready, underflow} !== 2'b00) begin errors++; $display("FAIL drained got %b exp 00", {rd_ready, underflow}); end
  endtask

  task automatic test_underflow();
    do_rst();
    do_read(1, 1);
    checks++; if ({overflow, underflow, range_err} !== 3'b010) begin errors++; $display("FAIL underflow_flag got %b exp 010", {overflow, underflow, range_err}); end
    checks++; if (layer_result_valid !== 1'b0 || layer_result_output !== '0) begin errors++; $display("FAIL underflow_out got valid=%b data=%0h exp 0/0", layer_result_valid, layer_result_output); end
    do_release();
    checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL empty_release got rd_ready=%b exp 0", rd_ready); end
    do_write(0, 0, DW'(7));
    do_commit();
    do_read(0, 0);
    checks++; if (layer_result_valid !== 1'b1 || layer_result_output !== DW'(7)) begin errors++; $display("FAIL rd_bank_kept got valid=%b data=%0d exp 1/7", layer_result_valid, layer_result_output); end
  endtask

  task automatic test_range();
    do_rst();
    do_write(1, 1, DW'(5));
    do_write(12, 0, DW'(6));
    checks++; if ({overflow, underflow, range_err} !== 3'b001 || fill_count !== 16'd1) begin errors++; $display("FAIL range_write got flags=%b fill=%0d exp 001/1", {overflow, underflow, range_err}, fill_count); end
    do_rst();
    do_commit();
    do_read(0, 12);
    checks++; if ({overflow, underflow, range_err} !== 3'b001) begin errors++; $display("FAIL range_read_flag got %b exp 001", {overflow, underflow, range_err}); end
    checks++; if (layer_result_valid !== 1'b0 || layer_result_output !== '0) begin errors++; $display("FAIL range_read_out got valid=%b data=%0h exp 0/0", layer_result_valid, layer_result_output); end
    do_read(0, 11);
    checks++; if (layer_result_valid !== 1'b1) begin errors++; $display("FAIL edge_col_read got valid=%b exp 1", layer_result_valid); end
  endtask

  task automatic test_auto_commit();
    do_rst();
    for (int i = 0; i < DEPTH - 1; i++) do_write(i / MW, i % MW, DW'(i));
    checks++; if (ac_rd_ready !== 1'b0 || ac_fill_count !== 16'd143) begin errors++; $display("FAIL auto_pre got rd=%b fill=%0d exp 0/143", ac_rd_ready, ac_fill_count); end
    do_write(11, 11, DW'(143));
    checks++; if ({ac_wr_ready, ac_rd_ready, ac_fill_count} !== {2'b11, 16'd0}) begin errors++; $display("FAIL auto_commit got %b/%0d exp 11/0", {ac_wr_ready, ac_rd_ready}, ac_fill_count); end
    checks++; if ({ac_ovf, ac_unf, ac_rng} !== 3'b000) begin errors++; $display("FAIL auto_flags got %b exp 000", {ac_ovf, ac_unf, ac_rng}); end
    // save_commit on the auto-commit write must count as a single commit
    do_rst();
    for (int i = 0; i < DEPTH - 1; i++) do_write(i / MW, i % MW, DW'(i));
    drive_clear();
    save_enable = 1; save_row_addr = 16'd11; save_col_addr = 16'd11; data_in = DW'(143); save_commit = 1;
    step(); drive_clear();
    checks++; if ({ac_wr_ready, ac_rd_ready, ac_ovf} !== 3'b110) begin errors++; $display("FAIL auto_plus_manual got %b exp 110", {ac_wr_ready, ac_rd_ready, ac_ovf}); end
    do_read(5, 7);
    checks++; if (ac_valid !== 1'b1 || ac_out !== DW'(67)) begin errors++; $display("FAIL auto_read got valid=%b data=%0d exp 1/67", ac_valid, ac_out); end
  endtask

  task automatic test_reset_midfill();
    do_rst();
    do_write(0, 0, DW'(42));
    do_commit();
    for (int i = 0; i < 50; i++) do_write(i / MW, i % MW, rnd_data());
    checks++; if (fill_count !== 16'd50) begin errors++; $display("FAIL midfill_count got %0d exp 50", fill_count); end
    drive_clear();
    rst = 1; read_signal = 1; read_row_addr = 16'd0; read_col_addr = 16'd0;
    step(); drive_clear();
    checks++; if (layer_result_valid !== 1'b0 || layer_result_output !== '0) begin errors++; $display("FAIL midfill_out got valid=%b data=%0h exp 0/0", layer_result_valid, layer_result_output); end
    checks++; if ({wr_ready, rd_ready, fill_count} !== {2'b10, 16'd0}) begin errors++; $display("FAIL midfill_state got %b/%0d exp 10/0", {wr_ready, rd_ready}, fill_count); end
    do_commit();
    do_read(2, 2);
    checks++; if (layer_result_valid !== 1'b1) begin errors++; $display("FAIL empty_map_read got valid=%b exp 1", layer_result_valid); end
  endtask

  task automatic test_random();
    do_rst();
    for (int k = 0; k < 1500; k++) begin
      drive_clear();
      rst           = ($urandom_range(0, 299) == 0);
      save_enable   = ($urandom_range(0, 3) != 0);
      save_row_addr = ($urandom_range(0, 19) == 0) ? 16'($urandom_range(12, 40)) : 16'($urandom_range(0, 11));
      save_col_addr = ($urandom_range(0, 19) == 0) ? 16'($urandom_range(12, 40)) : 16'($urandom_range(0, 11));
      data_in       = rnd_data();
      save_commit   = ($urandom_range(0, 24) == 0);
      read_signal   = ($urandom_range(0, 1) == 1);
      read_row_addr = ($urandom_range(0, 19) == 0) ? 16'($urandom_range(12, 40)) : 16'($urandom_range(0, 11));
      read_col_addr = ($urandom_range(0, 19) == 0) ? 16'($urandom_range(12, 40)) : 16'($urandom_range(0, 11));
      read_release  = ($urandom_range(0, 24) == 0);
      step();
      checks++; if ({wr_ready, rd_ready} !== {n_maps < 2, n_maps > 0}) begin errors++; $display("FAIL rnd_ready cyc %0d got %b exp %b", k, {wr_ready, rd_ready}, {n_maps < 2, n_maps > 0}); end
      checks++; if (fill_count !== 16'(fc)) begin errors++; $display("FAIL rnd_fill cyc %0d got %0d exp %0d", k, fill_count, fc); end
      checks++; if ({overflow, underflow, range_err} !== {e_ovf, e_unf, e_rng}) begin errors++; $display("FAIL rnd_flags cyc %0d got %b exp %b", k, {overflow, underflow, range_err}, {e_ovf, e_unf, e_rng}); end
      checks++; if (layer_result_valid !== e_valid) begin errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", k, layer_result_valid, e_valid); end
      if (e_known) begin
        checks++; if (layer_result_output !== e_data) begin errors++; $display("FAIL rnd_data cyc %0d got %0h exp %0h", k, layer_result_output, e_data); end
      end
    end
    drive_clear();
  endtask

  initial begin
    test_reset();
    test_fill_read();
    test_overflow();
    test_underflow();
    test_range();
    test_auto_commit();
    test_reset_midfill();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
